mm_arb_ctrl: RTL and testbench

Parametrised successor to the single-cycle main memory. One unified single-port storage array is shared by an instruction-fetch port and a data load/store port. A round-robin arbiter and a fixed-latency REQ/ACK handshake sit in front of the array, so the CPU can be tested against realistic wait states. The block drops into the computer simulator between risc_v_32 and the testbench.

---
 rtl/mm_arb_ctrl_pkg.sv | 17 +
 rtl/mm_rr_arb2.sv | 28 ++
 rtl/mm_arb_ctrl.sv | 154 +++++++++++++++
 tb/tb_mm_arb_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_arb_ctrl_pkg.sv
// rtl/mm_arb_ctrl_pkg.sv - shared encodings for the arbitrated main memory
package mm_arb_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_RD = 2'b00,
        MEM_SB = 2'b01,
        MEM_SH = 2'b10,
        MEM_SW = 2'b11
    } mem_wr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mm_rr_arb2.sv
// rtl/mm_rr_arb2.sv - two-requester round-robin arbiter with registered last-grant pointer
module mm_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_d,
    input  logic i_req_i,
    output logic o_gnt_d,
    output logic o_gnt_i
);

    logic r_prefer_d;

    always_comb begin
        o_gnt_d = i_en && i_req_d && (!i_req_i || r_prefer_d);
        o_gnt_i = i_en && i_req_i && !o_gnt_d;
    end

    // After reset data wins the first contested grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prefer_d <= 1'b1;
        end else if (o_gnt_d || o_gnt_i) begin
            r_prefer_d <= o_gnt_i;
        end
    end

endmodule

// File: rtl/mm_arb_ctrl.sv
// rtl/mm_arb_ctrl.sv - shared single-port memory with round-robin fetch/data arbitration and fixed latency
module mm_arb_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_ACK,
    input  logic              D_REQ,
    input  logic [1:0]        D_WR,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ACK,
    output logic              D_ERR,
    output logic              BUSY
);
    import mm_arb_ctrl_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    function automatic logic f_misaligned(input mem_wr_t wr, input logic [1:0] lane);
        case (wr)
            MEM_SH:  return lane[0];
            MEM_SW:  return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input mem_wr_t wr,
                                            input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] m;
        m = old;
        case (wr)
            MEM_SB:  m[{lane, 3'b000} +: 8]       = wd[7:0];
            MEM_SH:  m[{lane[1], 4'b0000} +: 16]  = wd[15:0];
            MEM_SW:  m = wd;
            default: m = old;
        endcase
        return m;
    endfunction

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_sel_d;
    mem_wr_t           r_wr;
    logic [AW+1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
    logic              r_i_ack, r_d_ack, r_d_err;

    logic              w_idle, w_gnt_d, w_gnt_i, w_access, w_is_st, w_err, w_do_wr;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_unused_hi;

    assign w_unused_hi = ^{I_ADDR[ADDR_W-1:AW+2], D_ADDR[ADDR_W-1:AW+2]};

    assign w_idle   = (r_state == S_IDLE);
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_idx    = r_addr[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_is_st  = r_sel_d && (r_wr != MEM_RD);
    assign w_err    = w_is_st && f_misaligned(r_wr, r_addr[1:0]);
    assign w_do_wr  = w_access && w_is_st && !w_err;

    mm_rr_arb2 u_arb (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_en    (w_idle),
        .i_req_d (D_REQ),
        .i_req_i (I_REQ),
        .o_gnt_d (w_gnt_d),
        .o_gnt_i (w_gnt_i)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_d || w_gnt_i) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_sel_d   <= 1'b0;
            r_wr      <= MEM_RD;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            if (w_gnt_d || w_gnt_i) begin
                r_cnt   <= CW'(LATENCY - 1);
                r_sel_d <= w_gnt_d;
                r_wr    <= w_gnt_d ? mem_wr_t'(D_WR) : MEM_RD;
                r_addr  <= w_gnt_d ? D_ADDR[AW+1:0] : I_ADDR[AW+1:0];
                r_wdata <= D_WDATA;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            // Stores report zero read data, including rejected misaligned ones.
            if (w_access) begin
                if (r_sel_d) begin
                    r_d_ack   <= 1'b1;
                    r_d_err   <= w_err;
                    r_d_rdata <= w_is_st ? '0 : w_word;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_word;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_wr) begin
            r_mem[w_idx] <= f_merge(w_word, r_wr, r_addr[1:0], r_wdata);
        end
    end

    assign I_RDATA = r_i_rdata;
    assign I_ACK   = r_i_ack;
    assign D_RDATA = r_d_rdata;
    assign D_ACK   = r_d_ack;
    assign D_ERR   = r_d_err;
    assign BUSY    = !w_idle;

endmodule

// File: tb/tb_mm_arb_ctrl.sv
// tb/tb_mm_arb_ctrl.sv - directed and randomized bench for mm_arb_ctrl with a byte-array model
module tb_mm_arb_ctrl;

    localparam int LATENCY = 2;
    localparam int BYTES   = 4096;

    logic        CLK, RST, I_REQ, D_REQ;
    logic [1:0]  D_WR;
    logic [31:0] I_ADDR, D_ADDR, D_WDATA;
    logic [31:0] I_RDATA, D_RDATA;
    logic        I_ACK, D_ACK, D_ERR, BUSY;

    int total = 0;
    int bad   = 0;
    bit last_d;
    logic [7:0] m_b [BYTES];

    mm_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LATENCY(LATENCY)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WR(D_WR), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK), .D_ERR(D_ERR), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] addr);
        int base;
        base = int'((addr % BYTES) / 4) * 4;
        return {m_b[base+3], m_b[base+2], m_b[base+1], m_b[base]};
    endfunction

    function automatic bit m_store(input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wd);
        int a;
        a = int'(addr % BYTES);
        case (wr)
            2'b01: m_b[a] = wd[7:0];
            2'b10: begin
                if (a % 2 != 0) return 1'b1;
                m_b[a] = wd[7:0];
                m_b[a+1] = wd[15:8];
            end
            2'b11: begin
                if (a % 4 != 0) return 1'b1;
                for (int k = 0; k < 4; k++) m_b[a+k] = wd[8*k +: 8];
            end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic d_op(input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic [31:0] exp_rd;
        bit exp_err;
        D_WR = wr; D_ADDR = addr; D_WDATA = wd; D_REQ = 1'b1; n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n++;
            if (D_ACK) break;
        end
        if (wr == 2'b00) begin
            exp_rd = m_word(addr); exp_err = 1'b0;
        end else begin
            exp_err = m_store(wr, addr, wd); exp_rd = 32'h0;
        end
        chk("d_latency", n, LATENCY + 1);
        chk("d_rdata", D_RDATA, exp_rd);
        chk("d_err", 32'(D_ERR), 32'(exp_err));
        chk("d_no_iack", 32'(I_ACK), 32'h0);
        D_REQ = 1'b0;
        last_d = 1'b1;
        @(negedge CLK);
        chk("d_ack_pulse", 32'(D_ACK), 32'h0);
        chk("d_idle", 32'(BUSY), 32'h0);
    endtask

    task automatic i_op(input logic [31:0] addr);
        int n;
        I_ADDR = addr; I_REQ = 1'b1; n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n++;
            if (I_ACK) break;
        end
        chk("i_latency", n, LATENCY + 1);
        chk("i_rdata", I_RDATA, m_word(addr));
        chk("i_no_dack", 32'(D_ACK), 32'h0);
        I_REQ = 1'b0;
        last_d = 1'b0;
        @(negedge CLK);
        chk("i_ack_pulse", 32'(I_ACK), 32'h0);
    endtask

    task automatic both_run(input int nacks, input logic [1:0] dwr, input logic [31:0] daddr,
                            input logic [31:0] dwd, input logic [31:0] iaddr);
        int cyc, prev, cnt;
        bit exp_d, is_d, e;
        exp_d = !last_d;
        D_WR = dwr; D_ADDR = daddr; D_WDATA = dwd; I_ADDR = iaddr;
        D_REQ = 1'b1; I_REQ = 1'b1;
        cyc = 0; prev = 0; cnt = 0;
        for (int c = 0; c < nacks * (LATENCY + 2) + 10; c++) begin
            @(negedge CLK);
            cyc++;
            if (I_ACK || D_ACK) begin
                is_d = D_ACK;
                chk("arb_one_ack", 32'(I_ACK & D_ACK), 32'h0);
                chk("arb_order", 32'(is_d), 32'(exp_d));
                chk("arb_spacing", cyc - prev, (cnt == 0) ? LATENCY + 1 : LATENCY + 2);
                if (is_d) begin
                    if (dwr == 2'b00) begin
                        chk("arb_drdata", D_RDATA, m_word(daddr));
                    end else begin
                        e = m_store(dwr, daddr, dwd);
                        chk("arb_derr", 32'(D_ERR), 32'(e));
                        chk("arb_dwr_rdata", D_RDATA, 32'h0);
                    end
                end else begin
                    chk("arb_irdata", I_RDATA, m_word(iaddr));
                end
                last_d = is_d;
                exp_d = !is_d;
                prev = cyc;
                cnt++;
                if (cnt == nacks) break;
            end
        end
        D_REQ = 1'b0; I_REQ = 1'b0;
        chk("arb_count", cnt, nacks);
        @(negedge CLK);
        chk("arb_idle", 32'(BUSY), 32'h0);
    endtask

    initial begin
        logic [1:0]  rwr;
        logic [31:0] ra, rd, old40;

        RST = 1'b0; I_REQ = 1'b1; D_REQ = 1'b1;
        D_WR = 2'b11; D_ADDR = 32'h10; D_WDATA = 32'hDEADBEEF; I_ADDR = 32'h10;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_iack", 32'(I_ACK), 32'h0);
        chk("rst_dack", 32'(D_ACK), 32'h0);
        chk("rst_derr", 32'(D_ERR), 32'h0);
        chk("rst_irdata", I_RDATA, 32'h0);
        chk("rst_drdata", D_RDATA, 32'h0);

        RST = 1'b1;
        last_d = 1'b0;
        both_run(2, 2'b11, 32'h10, 32'hDEADBEEF, 32'h10);
        chk("fetch_after_write", I_RDATA, 32'hDEADBEEF);

        d_op(2'b11, 32'h20, 32'h0);
        d_op(2'b01, 32'h21, 32'h000000AA);
        d_op(2'b10, 32'h22, 32'h00001234);
        d_op(2'b00, 32'h20, 32'h0);
        chk("byte_lanes", D_RDATA, 32'h1234AA00);

        d_op(2'b11, 32'h30, 32'h11223344);
        d_op(2'b11, 32'h31, 32'hFFFFFFFF);
        d_op(2'b10, 32'h33, 32'h0000FFFF);
        d_op(2'b00, 32'h32, 32'h0);
        chk("misaligned_kept", D_RDATA, 32'h11223344);

        i_op(32'h30);
        both_run(6, 2'b00, 32'h20, 32'h0, 32'h10);

        d_op(2'b11, 32'h1004, 32'hCAFEF00D);
        i_op(32'h0004);
        chk("wrap_alias", I_RDATA, 32'hCAFEF00D);

        d_op(2'b11, 32'h40, 32'h5A5AA5A5);
        old40 = m_word(32'h40);
        D_WR = 2'b11; D_ADDR = 32'h40; D_WDATA = 32'h12345678; D_REQ = 1'b1;
        @(negedge CLK);
        chk("wait_busy", 32'(BUSY), 32'h1);
        RST = 1'b0;
        #1;
        chk("midrst_busy", 32'(BUSY), 32'h0);
        D_REQ = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("midrst_no_ack", 32'({I_ACK, D_ACK}), 32'h0);
        end
        RST = 1'b1;
        last_d = 1'b0;
        i_op(32'h40);
        chk("midrst_unchanged", I_RDATA, old40);

        for (int k = 0; k < 16; k++) d_op(2'b11, 32'h100 + 32'(4 * k), $urandom);
        for (int k = 0; k < 30; k++) begin
            ra  = 32'h100 + 32'($urandom_range(0, 63));
            rwr = 2'($urandom_range(0, 3));
            rd  = $urandom;
            if ($urandom_range(0, 2) == 0) i_op(ra);
            else d_op(rwr, ra, rd);
        end
        ra  = 32'h100 + 32'($urandom_range(0, 63));
        rwr = 2'($urandom_range(0, 3));
        both_run(4, rwr, ra, $urandom, 32'h100 + 32'($urandom_range(0, 63)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
